// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 encodings and the burst writer FSM state type
package axi4_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP} bw_state_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO with full/empty/count
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer: packs a 32-bit valid/ready stream into single-outstanding AXI4 INCR write bursts
// Define AXI4_BURST_WRITER_TIMEOUT_EN to add a watchdog that aborts a stalled burst with error
module axi4_burst_writer
  import axi4_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN          = 4,
  parameter int FIFO_DEPTH         = 8,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                   total_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  bw_state_e state, state_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [15:0] remaining, accept_cnt, blen;
  logic [7:0] beat;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, push, pop, timeout;
  assign blen = remaining < 16'(BURST_LEN) ? remaining : 16'(BURST_LEN);
  assign busy = state != IDLE;
  assign s_ready = busy && !fifo_full && accept_cnt != '0;
  assign push = s_valid && s_ready;
  assign pop = m_axi_wvalid && m_axi_wready;
  assign m_axi_awid = '0;
  assign m_axi_awsize = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb = '1;
  assign m_axi_awvalid = state == ADDR;
  assign m_axi_wvalid = state == DATA && !fifo_empty;
  assign m_axi_wlast = m_axi_wvalid && beat == m_axi_awlen;
  assign m_axi_bready = state == RESP;
  sync_fifo_fwft #(.WIDTH(C_M_AXI_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(m_axi_aclk),
    .rst(m_axi_areset || timeout),
    .push(push),
    .din(s_data),
    .pop(pop),
    .dout(m_axi_wdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic hs, in_axi;
  assign hs = (m_axi_awvalid && m_axi_awready) || pop || (m_axi_bready && m_axi_bvalid);
  assign in_axi = state inside {ADDR, DATA, RESP};
  assign timeout = in_axi && !hs && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge m_axi_aclk)
    wd_cnt <= (m_axi_areset || hs || !in_axi) ? '0 : wd_cnt + TW'(1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge m_axi_aclk) state <= m_axi_areset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && total_beats != '0) state_n = FILL;
      FILL: if (16'(fifo_count) >= blen) state_n = ADDR;
      ADDR: if (m_axi_awready) state_n = DATA;
      DATA: if (pop && m_axi_wlast) state_n = RESP;
      RESP: if (m_axi_bvalid) state_n = remaining == blen ? IDLE : FILL;
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      cur_addr <= '0;
      remaining <= '0;
      accept_cnt <= '0;
      beat <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen <= '0;
      error <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) accept_cnt <= accept_cnt - 16'd1;
      if (state == IDLE && start) begin
        cur_addr <= base_addr & ~C_M_AXI_ADDR_WIDTH'(3);
        remaining <= total_beats;
        accept_cnt <= total_beats;
        error <= 1'b0;
        done <= total_beats == '0;
      end
      if (state == FILL && state_n == ADDR) begin
        m_axi_awaddr <= cur_addr;
        m_axi_awlen <= 8'(blen - 16'd1);
      end
      beat <= state == DATA ? beat + 8'(pop) : '0;
      // address wraps modulo the slave window by the natural register width
      if (state == RESP && m_axi_bvalid) begin
        error <= error || m_axi_bresp != AXI_RESP_OKAY;
        remaining <= remaining - blen;
        cur_addr <= cur_addr + C_M_AXI_ADDR_WIDTH'(blen << 2);
        done <= remaining == blen;
      end
      if (timeout) begin
        error <= 1'b1;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_burst_writer.sv
// tb_axi4_burst_writer: randomized stream/slave stimulus checked against a burst-level reference model
module tb_axi4_burst_writer;
  localparam int AW = 6, BL = 4, TO = 256;
  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] base_addr;
  logic [15:0] total_beats;
  logic busy, done, error;
  logic [31:0] s_data;
  logic s_valid, s_ready;
  logic [0:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  axi4_burst_writer dut (
    .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .error(error),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  // reference model: expected bursts, source words, expected slave memory
  int exp_addr[$], exp_len[$], obs_addr[$], obs_len[$];
  logic [31:0] src[$];
  logic [31:0] mem[16], mem_exp[16];
  int total, aw_i, w_i, b_i, acc, done_cnt, pend_b, err_burst, beat, cyc_n;
  int s_pct, aw_pct, wr_pct, b_pct;
  logic in_burst, exp_err, active, toggle, h_b;
  logic [AW-1:0] cur_aw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    h_b = 1'b0;
    if (active) begin
      chk("aw_w_exclusive", awvalid && wvalid, 0);
      if (awvalid) begin
        if (aw_i < exp_addr.size()) begin
          chk("awaddr", awaddr, exp_addr[aw_i]);
          chk("awlen", awlen, exp_len[aw_i] - 1);
        end else chk("extra_aw", 1, 0);
        chk("awsize", awsize, 3'b010);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 0);
      end
      if (wvalid) begin
        if (in_burst && w_i < total) begin
          chk("wdata", wdata, src[w_i]);
          chk("wlast", wlast, beat == exp_len[aw_i-1] - 1);
          chk("wstrb", wstrb, 4'hF);
        end else chk("wvalid_outside_burst", 1, 0);
      end else if (in_burst) chk("wvalid_gap", 0, 1);
      if (s_ready) chk("s_ready_beyond_total", acc < total, 1);
      if (err_burst >= 0 && b_i > err_burst && busy) chk("error_sticky", error, 1);
      if (done) done_cnt++;
      if (awvalid && awready) begin
        obs_addr.push_back(int'(awaddr));
        obs_len.push_back(int'(awlen));
        cur_aw = awaddr;
        in_burst = aw_i < exp_addr.size();
        aw_i++;
        beat = 0;
      end
      if (wvalid && wready && in_burst) begin
        mem[((int'(cur_aw) >> 2) + beat) % 16] = wdata;
        w_i++;
        beat++;
        if (beat == exp_len[aw_i-1]) begin
          in_burst = 1'b0;
          pend_b++;
        end
      end
      if (bvalid && bready) begin
        h_b = 1'b1;
        b_i++;
        pend_b--;
      end
      if (s_valid && s_ready) acc++;
    end
  end

  // stream source and AXI slave, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (!active) begin
      s_valid = 1'b0;
      awready = 1'b0;
      wready = 1'b0;
      bvalid = 1'b0;
      bresp = 2'b00;
    end else begin
      s_valid = acc < src.size() && (toggle ? cyc_n[0] : $urandom_range(0, 99) < s_pct);
      s_data = acc < src.size() ? src[acc] : 32'h0;
      awready = $urandom_range(0, 99) < aw_pct;
      wready = $urandom_range(0, 99) < wr_pct;
      if (h_b) begin
        bvalid = 1'b0;
        bresp = 2'b00;
      end
      if (!bvalid && pend_b > 0 && $urandom_range(0, 99) < b_pct) begin
        bvalid = 1'b1;
        bresp = b_i == err_burst ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic prep(input int base, input int n, input int err_b, input logic [31:0] d0);
    int a, rem, k, j;
    exp_addr.delete(); exp_len.delete(); src.delete(); obs_addr.delete(); obs_len.delete();
    for (int i = 0; i < n + 3; i++) src.push_back(d0 != 0 ? d0 + 32'(i) : $urandom);
    mem_exp = mem;
    a = base & 'h3C;
    rem = n;
    j = 0;
    while (rem > 0) begin
      k = rem < BL ? rem : BL;
      exp_addr.push_back(a);
      exp_len.push_back(k);
      for (int i = 0; i < k; i++) begin
        mem_exp[((a >> 2) + i) % 16] = src[j];
        j++;
      end
      a = (a + 4 * k) % 64;
      rem -= k;
    end
    total = n;
    err_burst = err_b;
    exp_err = err_b >= 0 && err_b < exp_addr.size();
    aw_i = 0; w_i = 0; b_i = 0; acc = 0; done_cnt = 0; pend_b = 0; beat = 0;
    in_burst = 1'b0;
  endtask

  task automatic launch(input int base, input int n);
    @(posedge clk); #1;
    base_addr = AW'(base);
    total_beats = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("error_clear_on_start", error, 0);
    chk("busy_after_start", busy, n != 0);
    chk("done_after_start", done, n == 0);
  endtask

  task automatic finish_cmd();
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("aw_count", aw_i, exp_addr.size());
    chk("w_count", w_i, total);
    chk("b_count", b_i, exp_addr.size());
    chk("accepted_words", acc, total);
    chk("busy_idle", busy, 0);
    chk("error_final", error, exp_err);
    for (int i = 0; i < 16; i++) chk("mem_readback", mem[i], mem_exp[i]);
  endtask

  task automatic check_zero();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_s_ready", s_ready, 0); chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0); chk("rst_bready", bready, 0); chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0); chk("rst_fifo_count", dut.fifo_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0; active = 1'b0; toggle = 1'b0;
    s_valid = 1'b0; s_data = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    s_pct = 100; aw_pct = 100; wr_pct = 100; b_pct = 100; cyc_n = 0; total = 0; err_burst = -1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    active = 1'b1;
    // single full burst with known data
    prep(0, 4, -1, 32'hA0); launch(0, 4); finish_cmd();
    chk("t1_awaddr", obs_addr.size() > 0 ? obs_addr[0] : -1, 'h00);
    chk("t1_awlen", obs_len.size() > 0 ? obs_len[0] : -1, 3);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[i], 32'hA0 + 32'(i));
    // three bursts, short tail
    prep('h10, 10, -1, 0); launch('h10, 10); finish_cmd();
    chk("t2_nbursts", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      chk("t2_addr1", obs_addr[1], 'h20); chk("t2_addr2", obs_addr[2], 'h30);
      chk("t2_len2", obs_len[2], 1);
    end
    // address wrap in the 64-byte window
    prep('h38, 8, -1, 0); launch('h38, 8); finish_cmd();
    chk("t3_wrap_addr", obs_addr.size() > 1 ? obs_addr[1] : -1, 'h08);
    // bursty stream and slow W channel
    toggle = 1'b1; wr_pct = 25;
    prep('h04, 10, -1, 0); launch('h04, 10); finish_cmd();
    toggle = 1'b0; wr_pct = 100;
    // SLVERR on first burst, then a clean command clears error
    prep(0, 8, 0, 0); launch(0, 8); finish_cmd();
    prep('h20, 4, -1, 0); launch('h20, 4); finish_cmd();
    // zero-length command
    prep('h20, 0, -1, 0); launch('h20, 0); finish_cmd();
    chk("t6_no_aw", obs_addr.size(), 0);
    for (int r = 0; r < 6; r++) begin
      int b, n;
      b = $urandom_range(0, 63); n = $urandom_range(1, 20);
      s_pct = $urandom_range(40, 100); aw_pct = $urandom_range(30, 100);
      wr_pct = $urandom_range(30, 100); b_pct = $urandom_range(30, 100);
      prep(b, n, r == 3 ? 1 : -1, 0); launch(b, n); finish_cmd();
    end
    s_pct = 100; aw_pct = 100; wr_pct = 100; b_pct = 100;
`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
    b_pct = 0;
    prep(0, 4, -1, 0); launch(0, 4);
    cyc = 0;
    while (!bready && cyc < 500) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!done && cyc < TO + 50) begin @(negedge clk); cyc++; end
    chk("timeout_cycles", cyc, TO);
    chk("timeout_error", error, 1);
    b_pct = 100;
`endif
    // reset in the middle of a burst
    prep(0, 8, -1, 0); launch(0, 8);
    cyc = 0;
    while (w_i < 2 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("reached_two_beats", w_i >= 2, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    active = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
